ble_cfg: RTL

- Configurable basic logic element (BLE): a K-input LUT feeding one configurable flip-flop, with the mode set by a serial configuration chain.
- Sits directly upstream of, and wraps, the flip-flop variants (plain, enable, sync reset, sync set). One config word selects which variant the element behaves as.
- Chains are daisy-chained through cfg_out to form a logic-block column.

---
 rtl/ble_cfg.sv | 103 ++++++++++
 1 files changed

// File: rtl/ble_cfg.sv
// Basic logic element: K-input LUT feeding one configurable flip-flop, programmed by a serial chain.
// Optional macro BLE_FF_INIT_EN adds a chain bit that presets the flop when the element goes active.
//
//   state    | meaning
//   S_UNCFG  | after reset, nothing loaded, outputs quiet
//   S_LOAD   | shifting a config word in, flop held at 0
//   S_ACTIVE | word complete, LUT/FF operating
module ble_cfg #(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_en,
  input  logic         cfg_in,
  output logic         cfg_out,
  output logic         cfg_done,
  input  logic [K-1:0] a,
  input  logic         ce,
  input  logic         sr,
  output logic         y
);

  localparam int LUT_N = 1 << K;
`ifdef BLE_FF_INIT_EN
  localparam int CFG_W = LUT_N + 5;
`else
  localparam int CFG_W = LUT_N + 4;
`endif
  localparam int CNT_W = $clog2(CFG_W + 1);

  typedef enum logic [1:0] {
    S_UNCFG,
    S_LOAD,
    S_ACTIVE
  } state_t;

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   chain_q, chain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_q, q_d;
  logic [CNT_W-1:0]   cnt_inc;

  logic [LUT_N-1:0]   lut;
  logic               reg_sel, ce_use, sr_use, sr_val;
  logic               lut_out;

  assign lut     = chain_q[LUT_N-1:0];
  assign reg_sel = chain_q[LUT_N];
  assign ce_use  = chain_q[LUT_N+1];
  assign sr_use  = chain_q[LUT_N+2];
  assign sr_val  = chain_q[LUT_N+3];
  assign lut_out = lut[a];

  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    cnt_inc = '0;
    if (cfg_en) begin
      chain_d = {chain_q[CFG_W-2:0], cfg_in};
      // a reload out of ACTIVE restarts the count with this bit as the first
      cnt_inc = (state_q == S_ACTIVE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
      cnt_d   = cnt_inc;
      if (cnt_inc == CNT_W'(CFG_W)) begin
        state_d = S_ACTIVE;
`ifdef BLE_FF_INIT_EN
        q_d     = chain_d[LUT_N+4];
`else
        q_d     = 1'b0;
`endif
      end else begin
        state_d = S_LOAD;
        q_d     = 1'b0;
      end
    end else if (state_q == S_ACTIVE) begin
      if (sr_use && sr) begin
        q_d = sr_val;
      end else if (!ce_use || ce) begin
        q_d = lut_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_UNCFG;
      chain_q <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign cfg_done = (state_q == S_ACTIVE);
  assign cfg_out  = chain_q[CFG_W-1];
  assign y        = cfg_done ? (reg_sel ? q_q : lut_out) : 1'b0;

endmodule
